// File: rtl/cpu_pkg.sv
// Shared types for the RV32I decode stage: instruction formats, opcodes and the decoded-beat record.
package cpu_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The PC travels beside this record in the stage because its width is a stage parameter.
  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [9:0]  func;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/cpu_decode_fields.sv
// Combinational RV32I decoder: splits an instruction word into fields, immediate, format and legality.
module cpu_decode_fields
  import cpu_pkg::*;
#(
  parameter int CHECK_FUNC = 1
) (
  input  logic [31:0] i_inst,
  output dec_t        o_dec
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       known_op;
  logic       func_ok;

  assign f3 = i_inst[14:12];
  assign f7 = i_inst[31:25];

  always_comb begin
    o_dec         = '0;
    o_dec.op      = i_inst[6:0];
    o_dec.rd      = i_inst[11:7];
    o_dec.rs1     = i_inst[19:15];
    o_dec.rs2     = i_inst[24:20];
    o_dec.func    = {f7, f3};
    o_dec.fmt     = FMT_X;
    o_dec.imm     = '0;
    known_op      = 1'b1;
    func_ok       = 1'b1;

    unique case (i_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        o_dec.fmt = FMT_U;
        o_dec.imm = {i_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        o_dec.fmt = FMT_J;
        o_dec.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      OP_BRANCH: begin
        o_dec.fmt = FMT_B;
        o_dec.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        func_ok   = (f3 != 3'd2) && (f3 != 3'd3);
      end
      OP_STORE: begin
        o_dec.fmt = FMT_S;
        o_dec.imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        func_ok   = (f3 <= 3'd2);
      end
      OP_REG: begin
        o_dec.fmt = FMT_R;
        func_ok   = (f7 == 7'h00) || ({f7, f3} == 10'h100) || ({f7, f3} == 10'h105);
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
        o_dec.fmt = FMT_I;
        o_dec.imm = {{20{i_inst[31]}}, i_inst[31:20]};
        if (i_inst[6:0] == OP_JALR)   func_ok = (f3 == 3'd0);
        if (i_inst[6:0] == OP_LOAD)   func_ok = (f3 != 3'd3) && (f3 <= 3'd5);
        if (i_inst[6:0] == OP_SYSTEM) func_ok = (f3 != 3'd4);
        if (i_inst[6:0] == OP_IMM) begin
          if (f3 == 3'd1) func_ok = (f7 == 7'h00);
          if (f3 == 3'd5) func_ok = (f7 == 7'h00) || (f7 == 7'h20);
        end
      end
      default: known_op = 1'b0;
    endcase

    // Funct-level checks are optional; unknown opcodes (incl. compressed encodings) are always illegal.
    o_dec.illegal = !known_op || ((CHECK_FUNC != 0) && !func_ok);
  end

endmodule

// File: rtl/cpu_decode_stage.sv
// Registered decode stage with output + skid slot so o_ready never depends combinationally on i_ready.
module cpu_decode_stage
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int CHECK_FUNC = 1,
  parameter int CNT_W      = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_inst,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [6:0]          o_op,
  output logic [4:0]          o_rd,
  output logic [4:0]          o_rs1,
  output logic [4:0]          o_rs2,
  output logic [9:0]          o_func,
  output logic [31:0]         o_imm,
  output fmt_e                o_fmt,
  output logic                o_illegal,
  output logic [CNT_W-1:0]    o_decoded_cnt,
  output logic [CNT_W-1:0]    o_illegal_cnt
);

  dec_t in_dec;

  cpu_decode_fields #(.CHECK_FUNC(CHECK_FUNC)) u_fields (
    .i_inst (i_inst),
    .o_dec  (in_dec)
  );

  logic                out_valid_q, out_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  dec_t                out_dec_q, out_dec_d;
  dec_t                skid_dec_q, skid_dec_d;
  logic [CNT_W-1:0]    dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0]    ill_cnt_q, ill_cnt_d;
  logic                accept;
  logic                deliver;

  always_comb begin
    accept       = i_valid && !skid_valid_q;
    deliver      = out_valid_q && i_ready;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_pc_d     = out_pc_q;
    skid_pc_d    = skid_pc_q;
    out_dec_d    = out_dec_q;
    skid_dec_d   = skid_dec_q;
    dec_cnt_d    = dec_cnt_q;
    ill_cnt_d    = ill_cnt_q;

    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || deliver) begin
      // Skid can only hold a beat while o_ready is low, so nothing new arrives in that case.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pc_d     = skid_pc_q;
        out_dec_d    = skid_dec_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_pc_d  = i_pc;
          out_dec_d = in_dec;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = i_pc;
      skid_dec_d   = in_dec;
    end

    // A beat delivered in a flush cycle still counts.
    if (deliver && (dec_cnt_q != '1)) dec_cnt_d = dec_cnt_q + CNT_W'(1);
    if (deliver && out_dec_q.illegal && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_pc_q     <= '0;
      skid_pc_q    <= '0;
      out_dec_q    <= '0;
      skid_dec_q   <= '0;
      dec_cnt_q    <= '0;
      ill_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_pc_q     <= out_pc_d;
      skid_pc_q    <= skid_pc_d;
      out_dec_q    <= out_dec_d;
      skid_dec_q   <= skid_dec_d;
      dec_cnt_q    <= dec_cnt_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign o_ready       = !skid_valid_q;
  assign o_valid       = out_valid_q;
  assign o_pc          = out_pc_q;
  assign o_op          = out_dec_q.op;
  assign o_rd          = out_dec_q.rd;
  assign o_rs1         = out_dec_q.rs1;
  assign o_rs2         = out_dec_q.rs2;
  assign o_func        = out_dec_q.func;
  assign o_imm         = out_dec_q.imm;
  assign o_fmt         = out_dec_q.fmt;
  assign o_illegal     = out_dec_q.illegal;
  assign o_decoded_cnt = dec_cnt_q;
  assign o_illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Self-checking bench: two stage instances (funct checks + 4-bit counters, opcode-only + 16-bit counters)
// share one stimulus stream and are compared against a queue-based reference of the stage.
module tb_cpu_decode_stage;
  import cpu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_ready;
  logic [31:0] i_inst, i_pc;

  logic        o_ready_a, o_valid_a, o_illegal_a, o_ready_b, o_valid_b, o_illegal_b;
  logic [31:0] o_pc_a, o_imm_a, o_pc_b, o_imm_b;
  logic [6:0]  o_op_a, o_op_b;
  logic [4:0]  o_rd_a, o_rs1_a, o_rs2_a, o_rd_b, o_rs1_b, o_rs2_b;
  logic [9:0]  o_func_a, o_func_b;
  fmt_e        o_fmt_a, o_fmt_b;
  logic [3:0]  o_decoded_cnt_a, o_illegal_cnt_a;
  logic [15:0] o_decoded_cnt_b, o_illegal_cnt_b;

  always #5 i_clk = ~i_clk;

  cpu_decode_stage #(.PC_WIDTH(32), .CHECK_FUNC(1), .CNT_W(4)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_inst(i_inst), .i_pc(i_pc), .o_valid(o_valid_a), .i_ready(i_ready), .o_pc(o_pc_a),
    .o_op(o_op_a), .o_rd(o_rd_a), .o_rs1(o_rs1_a), .o_rs2(o_rs2_a), .o_func(o_func_a),
    .o_imm(o_imm_a), .o_fmt(o_fmt_a), .o_illegal(o_illegal_a),
    .o_decoded_cnt(o_decoded_cnt_a), .o_illegal_cnt(o_illegal_cnt_a));

  cpu_decode_stage #(.PC_WIDTH(32), .CHECK_FUNC(0), .CNT_W(16)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_inst(i_inst), .i_pc(i_pc), .o_valid(o_valid_b), .i_ready(i_ready), .o_pc(o_pc_b),
    .o_op(o_op_b), .o_rd(o_rd_b), .o_rs1(o_rs1_b), .o_rs2(o_rs2_b), .o_func(o_func_b),
    .o_imm(o_imm_b), .o_fmt(o_fmt_b), .o_illegal(o_illegal_b),
    .o_decoded_cnt(o_decoded_cnt_b), .o_illegal_cnt(o_illegal_cnt_b));

  typedef struct { logic [31:0] inst; logic [31:0] pc; } beat_t;

  beat_t q[$];
  int    dc_a = 0, ic_a = 0, dc_b = 0, ic_b = 0;
  int    errors = 0, checks = 0;

  // Sign-extend a raw immediate of the given bit count by two's-complement arithmetic.
  function automatic logic [31:0] sext(input logic [31:0] raw, input int bits);
    if (raw[bits-1]) return raw - (32'd1 << bits);
    return raw;
  endfunction

  function automatic void ref_decode(input logic [31:0] inst, input bit chk,
                                     output logic [31:0] imm, output fmt_e fmt, output bit ill);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [9:0] fn;
    bit         ok;
    f3  = inst[14:12];
    f7  = inst[31:25];
    fn  = {f7, f3};
    imm = 32'd0;
    fmt = FMT_X;
    ok  = 1'b1;
    case (inst[6:0])
      7'b0110111, 7'b0010111: begin fmt = FMT_U; imm = inst & 32'hFFFF_F000; end
      7'b1101111: begin
        fmt = FMT_J;
        imm = sext({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
      end
      7'b1100011: begin
        fmt = FMT_B;
        imm = sext({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
        ok  = !(f3 inside {3'd2, 3'd3});
      end
      7'b0100011: begin
        fmt = FMT_S;
        imm = sext({20'b0, inst[31:25], inst[11:7]}, 12);
        ok  = (f3 < 3'd3);
      end
      7'b0110011: begin fmt = FMT_R; ok = fn inside {[10'h000:10'h007], 10'h100, 10'h105}; end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        fmt = FMT_I;
        imm = sext({20'b0, inst[31:20]}, 12);
        if (inst[6:0] == 7'b1100111) ok = (f3 == 3'd0);
        if (inst[6:0] == 7'b0000011) ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if (inst[6:0] == 7'b1110011) ok = (f3 != 3'd4);
        if (inst[6:0] == 7'b0010011 && f3 == 3'd1) ok = (f7 == 7'h00);
        if (inst[6:0] == 7'b0010011 && f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      end
      default: fmt = FMT_X;
    endcase
    ill = (fmt == FMT_X) || (chk && !ok);
  endfunction

  // Reference stage: a FIFO of at most two accepted beats; head is what the stage presents.
  always @(posedge i_clk) begin
    int          n;
    logic [31:0] imm;
    fmt_e        fmt;
    bit          ill;
    if (!i_rst_n) begin
      q.delete();
      dc_a = 0; ic_a = 0; dc_b = 0; ic_b = 0;
    end else begin
      n = q.size();
      if (n > 0 && i_ready) begin
        ref_decode(q[0].inst, 1'b1, imm, fmt, ill);
        if (dc_a < 15) dc_a++;
        if (ill && ic_a < 15) ic_a++;
        ref_decode(q[0].inst, 1'b0, imm, fmt, ill);
        if (dc_b < 65535) dc_b++;
        if (ill && ic_b < 65535) ic_b++;
        void'(q.pop_front());
      end
      if (i_flush) q.delete();
      else if (i_valid && n < 2) q.push_back('{i_inst, i_pc});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic checkStage();
    logic [31:0] imm;
    fmt_e        fmt;
    bit          ill;
    checkOutput("valid_a", 32'(o_valid_a), 32'(q.size() > 0));
    checkOutput("valid_b", 32'(o_valid_b), 32'(q.size() > 0));
    checkOutput("ready_a", 32'(o_ready_a), 32'(q.size() < 2));
    checkOutput("ready_b", 32'(o_ready_b), 32'(q.size() < 2));
    checkOutput("dcnt_a", 32'(o_decoded_cnt_a), dc_a);
    checkOutput("icnt_a", 32'(o_illegal_cnt_a), ic_a);
    checkOutput("dcnt_b", 32'(o_decoded_cnt_b), dc_b);
    checkOutput("icnt_b", 32'(o_illegal_cnt_b), ic_b);
    if (q.size() > 0) begin
      ref_decode(q[0].inst, 1'b1, imm, fmt, ill);
      checkOutput("pc_a", o_pc_a, q[0].pc);
      checkOutput("op_a", 32'(o_op_a), 32'(q[0].inst[6:0]));
      checkOutput("rd_a", 32'(o_rd_a), 32'(q[0].inst[11:7]));
      checkOutput("rs1_a", 32'(o_rs1_a), 32'(q[0].inst[19:15]));
      checkOutput("rs2_a", 32'(o_rs2_a), 32'(q[0].inst[24:20]));
      checkOutput("func_a", 32'(o_func_a), 32'({q[0].inst[31:25], q[0].inst[14:12]}));
      checkOutput("imm_a", o_imm_a, imm);
      checkOutput("fmt_a", 32'(o_fmt_a), 32'(fmt));
      checkOutput("ill_a", 32'(o_illegal_a), 32'(ill));
      ref_decode(q[0].inst, 1'b0, imm, fmt, ill);
      checkOutput("pc_b", o_pc_b, q[0].pc);
      checkOutput("imm_b", o_imm_b, imm);
      checkOutput("fmt_b", 32'(o_fmt_b), 32'(fmt));
      checkOutput("ill_b", 32'(o_illegal_b), 32'(ill));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic rdy, input logic fl, input logic rn);
    i_valid = v;
    i_inst  = inst;
    i_pc    = pc;
    i_ready = rdy;
    i_flush = fl;
    i_rst_n = rn;
    @(posedge i_clk);
    @(negedge i_clk);
    checkStage();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(10)];
    case ($urandom_range(3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    @(negedge i_clk);
    applyStimulus(1'b1, 32'h0050_0093, 32'h40, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0050_0093, 32'h44, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_valid", 32'(o_valid_a), 32'd0);
    checkOutput("rst_ready", 32'(o_ready_a), 32'd1);
    checkOutput("rst_pc", o_pc_a, 32'd0);
    checkOutput("rst_imm", o_imm_a, 32'd0);
    checkOutput("rst_fields", 32'({o_op_a, o_rd_a, o_rs1_a, o_rs2_a, o_func_a}), 32'd0);
    checkOutput("rst_fmt_ill", 32'({o_fmt_a, o_illegal_a}), 32'd0);

    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, 1'b1);
    checkOutput("addi_valid", 32'(o_valid_a), 32'd1);
    checkOutput("addi_rd", 32'(o_rd_a), 32'd1);
    checkOutput("addi_rs1", 32'(o_rs1_a), 32'd0);
    checkOutput("addi_imm", o_imm_a, 32'd5);
    checkOutput("addi_fmt", 32'(o_fmt_a), 32'(FMT_I));
    checkOutput("addi_pc", o_pc_a, 32'h100);
    checkOutput("addi_ill", 32'(o_illegal_a), 32'd0);
    applyStimulus(1'b1, 32'h1234_5137, 32'h104, 1'b1, 1'b0, 1'b1);
    checkOutput("lui_imm", o_imm_a, 32'h1234_5000);
    checkOutput("lui_rd", 32'(o_rd_a), 32'd2);
    applyStimulus(1'b1, 32'hFFDF_F06F, 32'h108, 1'b1, 1'b0, 1'b1);
    checkOutput("jal_imm", o_imm_a, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'hFE00_0EE3, 32'h10C, 1'b1, 1'b0, 1'b1);
    checkOutput("beq_imm", o_imm_a, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'h4020_8033, 32'h110, 1'b1, 1'b0, 1'b1);
    checkOutput("sub_func", 32'(o_func_a), 32'h100);
    checkOutput("sub_ill", 32'(o_illegal_a), 32'd0);
    applyStimulus(1'b1, 32'h0220_8033, 32'h114, 1'b1, 1'b0, 1'b1);
    checkOutput("mul_ill_chk", 32'(o_illegal_a), 32'd1);
    checkOutput("mul_ill_nochk", 32'(o_illegal_b), 32'd0);
    checkOutput("mul_fmt_nochk", 32'(o_fmt_b), 32'(FMT_R));
    applyStimulus(1'b1, 32'h0000_0000, 32'h118, 1'b1, 1'b0, 1'b1);
    checkOutput("zero_ill_a", 32'(o_illegal_a), 32'd1);
    checkOutput("zero_ill_b", 32'(o_illegal_b), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure: two beats fill output + skid, the third is held upstream until release.
    applyStimulus(1'b1, 32'h0010_0093, 32'h200, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_ready1", 32'(o_ready_a), 32'd1);
    applyStimulus(1'b1, 32'h0020_0093, 32'h204, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_ready2", 32'(o_ready_a), 32'd0);
    applyStimulus(1'b1, 32'h0030_0093, 32'h208, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_hold_pc", o_pc_a, 32'h200);
    applyStimulus(1'b1, 32'h0030_0093, 32'h208, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_order2", o_pc_a, 32'h204);
    applyStimulus(1'b1, 32'h0030_0093, 32'h208, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_order3", o_pc_a, 32'h208);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Flush with the skid full and a same-cycle beat offered.
    applyStimulus(1'b1, 32'h0010_0093, 32'h300, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0020_0093, 32'h304, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0030_0093, 32'h308, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_valid", 32'(o_valid_a), 32'd0);
    checkOutput("flush_ready", 32'(o_ready_a), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_gone", 32'(o_valid_a), 32'd0);

    // Counter saturation: 20 delivered beats, every fourth one illegal.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      applyStimulus(1'b1, (k % 4 == 0) ? 32'h0 : 32'h0050_0093, 32'h400 + 4 * k, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("sat_dcnt_a", 32'(o_decoded_cnt_a), 32'd15);
    checkOutput("sat_icnt_a", 32'(o_illegal_cnt_a), 32'd5);
    checkOutput("sat_dcnt_b", 32'(o_decoded_cnt_b), 32'd20);
    checkOutput("sat_icnt_b", 32'(o_illegal_cnt_b), 32'd5);

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 600; k++)
      applyStimulus($urandom_range(9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC,
                    $urandom_range(9) < 6, $urandom_range(49) == 0, $urandom_range(99) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
